// File: rtl/spi_mem_resp.sv
// SPI mode-0 memory responder: serves READ (0x03), FAST_READ (0x0B) and WRITE (0x02)
// from an internal byte array, with all SPI inputs oversampled on clk.
module spi_mem_resp #(
    parameter int unsigned MEM_BYTES = 8192,
    parameter int unsigned ADDR_BITS = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic cs_n,
    input  logic spi_sclk,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic busy,
    output logic cmd_err
);

    localparam int unsigned IDX_W   = $clog2(MEM_BYTES);
    localparam int unsigned CNT_MAX = (ADDR_BITS > 8) ? ADDR_BITS : 8;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_WRITE     = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_RDATA, ST_WDATA, ST_IGNORE
    } state_t;

    logic [1:0] cs_sync, sclk_sync, mosi_sync;
    logic       cs_prev, sclk_prev;
    logic       cs_rise, cs_fall, sclk_rise, sclk_fall, mosi_bit;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [6:0]       shreg_q, shreg_d;
    logic [7:0]       cmd_q, cmd_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic [7:0]       tx_q, tx_d;
    logic             miso_d, busy_d, err_d;
    logic [7:0]       shift_in;

    logic [7:0]       mem [MEM_BYTES];
    logic             mem_we;
    logic [7:0]       mem_wdata;
    logic [IDX_W-1:0] rd_idx;
    logic [7:0]       mem_rdata;

    // Two-flop synchronisers plus previous-value flops for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync   <= '0;
            sclk_sync <= '0;
            mosi_sync <= '0;
            cs_prev   <= 1'b0;
            sclk_prev <= 1'b0;
        end else begin
            cs_sync   <= {cs_sync[0], cs_n};
            sclk_sync <= {sclk_sync[0], spi_sclk};
            mosi_sync <= {mosi_sync[0], spi_mosi};
            cs_prev   <= cs_sync[1];
            sclk_prev <= sclk_sync[1];
        end
    end

    assign cs_rise   =  cs_sync[1] & ~cs_prev;
    assign cs_fall   = ~cs_sync[1] &  cs_prev;
    assign sclk_rise =  sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[1] &  sclk_prev;
    assign mosi_bit  =  mosi_sync[1];
    assign shift_in  = {shreg_q, mosi_bit};

    // A full byte on the miso side means the next fetch is from the following address
    assign rd_idx    = (cnt_q == CNT_W'(8)) ? addr_q + IDX_W'(1) : addr_q;
    assign mem_rdata = mem[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            cmd_q    <= '0;
            addr_q   <= '0;
            tx_q     <= '0;
            spi_miso <= 1'b0;
            busy     <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            cmd_q    <= cmd_d;
            addr_q   <= addr_d;
            tx_q     <= tx_d;
            spi_miso <= miso_d;
            busy     <= busy_d;
            cmd_err  <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shreg_d   = shreg_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        tx_d      = tx_q;
        miso_d    = spi_miso;
        err_d     = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = shift_in;

        // A chip-select release overrides any SCLK edge seen in the same cycle
        if (cs_rise) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            miso_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = ST_CMD;
                        cnt_d   = '0;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise) begin
                        shreg_d = shift_in[6:0];
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            cnt_d = '0;
                            if (shift_in == CMD_READ || shift_in == CMD_FAST_READ ||
                                shift_in == CMD_WRITE) begin
                                cmd_d   = shift_in;
                                state_d = ST_ADDR;
                            end else begin
                                err_d   = 1'b1;
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end
                ST_ADDR: begin
                    if (sclk_rise) begin
                        addr_d = {addr_q[IDX_W-2:0], mosi_bit};
                        cnt_d  = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                            cnt_d = '0;
                            case (cmd_q)
                                CMD_FAST_READ: state_d = ST_DUMMY;
                                CMD_READ:      state_d = ST_RDATA;
                                default:       state_d = ST_WDATA;
                            endcase
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sclk_rise) begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            cnt_d   = '0;
                            state_d = ST_RDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (sclk_fall) begin
                        if (cnt_q == CNT_W'(0) || cnt_q == CNT_W'(8)) begin
                            addr_d = rd_idx;
                            miso_d = mem_rdata[7];
                            tx_d   = {mem_rdata[6:0], 1'b0};
                            cnt_d  = CNT_W'(1);
                        end else begin
                            miso_d = tx_q[7];
                            tx_d   = {tx_q[6:0], 1'b0};
                            cnt_d  = cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_WDATA: begin
                    if (sclk_rise) begin
                        shreg_d = shift_in[6:0];
                        cnt_d   = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(7)) begin
                            mem_we = 1'b1;
                            addr_d = addr_q + IDX_W'(1);
                            cnt_d  = '0;
                        end
                    end
                end
                ST_IGNORE: ;
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_ADDR) || (state_d == ST_DUMMY) ||
                 (state_d == ST_RDATA) || (state_d == ST_WDATA);
        if (state_d != ST_RDATA) begin
            miso_d = 1'b0;
        end
    end

    // Byte array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_spi_mem_resp.sv
// Bench for spi_mem_resp: directed scenarios plus randomized write/read traffic,
// all compared against a plain byte-array model of the memory.
module tb_spi_mem_resp;

    localparam int unsigned MEM_BYTES = 8192;

    logic clk = 1'b0;
    logic rst, cs_n, spi_sclk, spi_mosi;
    logic spi_miso, busy, cmd_err;

    spi_mem_resp #(.MEM_BYTES(MEM_BYTES), .ADDR_BITS(24)) dut (
        .clk      (clk),
        .rst      (rst),
        .cs_n     (cs_n),
        .spi_sclk (spi_sclk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .busy     (busy),
        .cmd_err  (cmd_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int err_cycles = 0;
    int viol = 0;
    logic watch = 1'b0;
    logic [7:0] model_mem [MEM_BYTES];
    logic [7:0] wq [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (cmd_err === 1'b1) err_cycles++;
        if (watch && (busy !== 1'b0 || spi_miso !== 1'b0)) viol++;
    end

    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SPI bit: data set in the low phase, MISO sampled at the rising edge
    task automatic spi_bit(input logic b, output logic rb, output logic bz);
        spi_mosi = b;
        clk_wait(6);
        rb = spi_miso;
        bz = busy;
        spi_sclk = 1'b1;
        clk_wait(6);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic bz_all);
        logic rb, bz;
        bz_all = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], rb, bz);
            rx[i]  = rb;
            bz_all = bz_all & bz;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        clk_wait(4);
    endtask

    task automatic cs_end();
        clk_wait(6);
        cs_n = 1'b1;
        clk_wait(8);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr);
        logic [7:0] rx;
        logic bz;
        cs_begin();
        spi_byte(cmd, rx, bz);
        for (int k = 0; k < 3; k++) spi_byte(addr[23-8*k -: 8], rx, bz);
    endtask

    task automatic do_write(input logic [23:0] addr, input string tag);
        logic [7:0] rx;
        logic bz;
        send_hdr(8'h02, addr);
        for (int i = 0; i < wq.size(); i++) begin
            spi_byte(wq[i], rx, bz);
            check({tag, "_wbusy"}, 32'(bz), 32'd1);
            model_mem[(int'(addr) + i) % MEM_BYTES] = wq[i];
        end
        cs_end();
    endtask

    task automatic do_read(input logic [7:0] cmd, input logic [23:0] addr, input int n,
                           input string tag);
        logic [7:0] rx;
        logic bz;
        send_hdr(cmd, addr);
        if (cmd == 8'h0B) begin
            spi_byte(8'h00, rx, bz);
            check({tag, "_dummy_miso"}, 32'(rx), 32'd0);
        end
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, rx, bz);
            check({tag, "_data"}, 32'(rx), 32'(model_mem[(int'(addr) + i) % MEM_BYTES]));
            check({tag, "_rbusy"}, 32'(bz), 32'd1);
        end
        cs_end();
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #10000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] rx;
        logic rb, bz;
        logic [23:0] wa, ra;
        int len;

        for (int i = 0; i < int'(MEM_BYTES); i++) model_mem[i] = 8'h00;
        rst = 1'b1; cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        clk_wait(3);
        check("reset_miso", 32'(spi_miso), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cmd_err", 32'(cmd_err), 32'd0);
        rst = 1'b0;
        clk_wait(6);

        // Write then read back
        wq = {8'hA5, 8'h3C};
        do_write(24'h000010, "wr10");
        do_read(8'h03, 24'h000010, 2, "rd10");

        // Fast read with dummy byte
        wq = {8'h81};
        do_write(24'h000020, "wr20");
        do_read(8'h0B, 24'h000020, 1, "frd20");

        // Wrap-around and address aliasing
        wq = {8'h5A};
        do_write(24'h00001F, "wr1f");
        wq = {8'h11, 8'h22};
        do_write(24'h001FFF, "wrwrap");
        do_read(8'h03, 24'h001FFF, 2, "rdwrap");
        do_read(8'h03, 24'h000000, 1, "rd0");
        do_read(8'h03, 24'h00201F, 1, "rdalias");

        // Unsupported command followed by a write-looking payload
        err_cycles = 0;
        watch = 1'b1;
        cs_begin();
        spi_byte(8'h9F, rx, bz);
        spi_byte(8'h02, rx, bz);
        spi_byte(8'h00, rx, bz);
        spi_byte(8'h00, rx, bz);
        spi_byte(8'h10, rx, bz);
        spi_byte(8'hEE, rx, bz);
        cs_end();
        watch = 1'b0;
        check("unsup_err_pulses", 32'(err_cycles), 32'd1);
        check("unsup_busy_miso", 32'(viol), 32'd0);
        do_read(8'h03, 24'h000010, 2, "unsup_mem");

        // Partial write byte is discarded
        wq = {8'h77};
        do_write(24'h000040, "wr40");
        send_hdr(8'h02, 24'h000040);
        for (int i = 0; i < 5; i++) spi_bit(1'b0, rb, bz);
        cs_end();
        check("partial_busy", 32'(busy), 32'd0);
        do_read(8'h03, 24'h000040, 1, "partial_rd");

        // Reset in the third bit of a read data byte
        wq = {8'hFF, 8'h00};
        do_write(24'h000060, "wr60");
        send_hdr(8'h03, 24'h000060);
        spi_bit(1'b0, rb, bz);
        spi_bit(1'b0, rb, bz);
        spi_mosi = 1'b0;
        clk_wait(6);
        check("rst_pre_miso", 32'(spi_miso), 32'd1);
        spi_sclk = 1'b1;
        clk_wait(2);
        check("rst_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        clk_wait(3);
        spi_sclk = 1'b0;
        cs_n = 1'b1;
        clk_wait(3);
        rst = 1'b0;
        clk_wait(8);
        do_read(8'h03, 24'h000060, 2, "rst_rd");

        // Randomized write/read traffic with aliased read addresses
        for (int it = 0; it < 8; it++) begin
            wa  = 24'($urandom);
            len = $urandom_range(1, 4);
            wq.delete();
            for (int i = 0; i < len; i++) wq.push_back(8'($urandom));
            do_write(wa, "rnd_wr");
            ra = (wa & 24'h001FFF) | (24'($urandom) & 24'hFFE000);
            do_read(($urandom_range(0, 1) == 1) ? 8'h0B : 8'h03, ra, len, "rnd_rd");
        end

        check("cmd_err_total", 32'(err_cycles), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
